// File: rtl/uart_tx_sched.sv
// ---------------------------------------------------------------------------
// uart_tx_sched
//
// Transmit-side scheduler between the IOBUS and a byte-serial UART driver.
// Bytes written by software are queued in a circular FIFO and handed to the
// UART driver one at a time, in FIFO order, through its start/ready handshake.
// A status word reports fill level, full/empty, an "all sent" idle flag and a
// sticky overflow flag.
//
// Handshake with the UART driver: TX_READY high means the driver is idle and
// can take a byte. The scheduler pops a byte only while TX_READY is high, then
// raises TX_START for exactly one cycle with TX_DATA stable. It then waits for
// TX_READY to fall (busy), giving up after BUSY_TO cycles, and then waits for
// TX_READY to rise again (done) before it may launch the next byte.
//
// Ports:
//   CLK        system clock, all logic on posedge
//   RST        synchronous active-high reset
//   WR_EN      one-cycle push strobe
//   WR_DATA    byte to queue
//   CLR_OVF    one-cycle strobe clearing the sticky overflow flag
//   TX_READY   UART driver idle / able to accept a byte
//   TX_START   one-cycle start pulse to the UART driver
//   TX_DATA    byte for the UART driver, held between pulses
//   STATUS     {16'b0, OVERFLOW, IDLE, FULL, EMPTY, 4'b0, COUNT[7:0]}
//   DBG_STATE  current FSM state (0 IDLE, 1 LAUNCH, 2 WAIT_BUSY, 3 WAIT_DONE)
// ---------------------------------------------------------------------------
module uart_tx_sched #(
    parameter int DEPTH   = 16,
    parameter int CW      = 5,
    parameter int BUSY_TO = 8
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        WR_EN,
    input  logic [7:0]  WR_DATA,
    input  logic        CLR_OVF,
    input  logic        TX_READY,
    output logic        TX_START,
    output logic [7:0]  TX_DATA,
    output logic [31:0] STATUS,
    output logic [1:0]  DBG_STATE
);

    localparam int            AW          = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL_CNT    = CW'(DEPTH);
    localparam logic [7:0]    BUSY_TO_M1  = 8'(BUSY_TO - 1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_LAUNCH    = 2'd1,
        S_WAIT_BUSY = 2'd2,
        S_WAIT_DONE = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_next_state;

    logic [7:0]      r_mem [DEPTH];
    logic [AW-1:0]   r_rd_ptr;
    logic [AW-1:0]   r_wr_ptr;
    logic [CW-1:0]   r_count;
    logic            r_empty;
    logic            r_full;
    logic            r_ovf;
    logic            r_idle;
    logic            r_tx_start;
    logic [7:0]      r_tx_data;
    logic [7:0]      r_to_cnt;

    logic            w_pop;
    logic            w_push;
    logic            w_drop;
    logic            w_to_clear;
    logic            w_to_inc;
    logic [CW-1:0]   w_count_next;

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            // Only registered FIFO contents are considered, so a write into
            // an empty FIFO is never bypassed straight to the driver.
            S_IDLE: begin
                if (!r_empty && TX_READY) begin
                    w_next_state = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                w_next_state = S_WAIT_BUSY;
            end
            // Give up waiting for busy after BUSY_TO cycles so a driver whose
            // ready never visibly drops cannot stall the queue.
            S_WAIT_BUSY: begin
                if (!TX_READY || (r_to_cnt == BUSY_TO_M1)) begin
                    w_next_state = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (TX_READY) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM: output / datapath control decode
    // -----------------------------------------------------------------------
    always_comb begin
        w_pop      = (r_state == S_IDLE) && (w_next_state == S_LAUNCH);
        w_to_clear = (r_state == S_LAUNCH);
        w_to_inc   = (r_state == S_WAIT_BUSY) && TX_READY;
        // A full FIFO still accepts a byte when a pop frees a slot this cycle.
        w_push     = WR_EN && (!r_full || w_pop);
        w_drop     = WR_EN && r_full && !w_pop;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + 1'b1;
            2'b01:   w_count_next = r_count - 1'b1;
            default: w_count_next = r_count;
        endcase
    end

    // -----------------------------------------------------------------------
    // FIFO storage (no reset needed; validity is tracked by the pointers)
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (!RST && w_push) begin
            r_mem[r_wr_ptr] <= WR_DATA;
        end
    end

    // -----------------------------------------------------------------------
    // FIFO pointers, flags and status
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_empty  <= 1'b1;
            r_full   <= 1'b0;
            r_ovf    <= 1'b0;
            r_idle   <= 1'b1;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= w_count_next;
            r_empty <= (w_count_next == '0);
            r_full  <= (w_count_next == FULL_CNT);
            // Flags are registered from next-cycle values so that they line
            // up with the state and count they describe.
            r_idle  <= (w_next_state == S_IDLE) && (w_count_next == '0);
            // A fresh overflow beats a coincident clear.
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (CLR_OVF) begin
                r_ovf <= 1'b0;
            end
        end
    end

    // -----------------------------------------------------------------------
    // UART driver interface and busy timeout counter
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_tx_start <= 1'b0;
            r_tx_data  <= 8'h00;
            r_to_cnt   <= 8'h00;
        end else begin
            r_tx_start <= (w_next_state == S_LAUNCH);
            // TX_DATA only moves on a pop, so it stays stable between pulses.
            if (w_pop) begin
                r_tx_data <= r_mem[r_rd_ptr];
            end
            if (w_to_clear) begin
                r_to_cnt <= 8'h00;
            end else if (w_to_inc) begin
                r_to_cnt <= r_to_cnt + 8'h01;
            end
        end
    end

    assign TX_START  = r_tx_start;
    assign TX_DATA   = r_tx_data;
    assign STATUS    = {16'h0000, r_ovf, r_idle, r_full, r_empty, 4'h0, 8'(r_count)};
    assign DBG_STATE = r_state;

endmodule

// File: tb/tb_uart_tx_sched.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_sched
//
// Directed bench for uart_tx_sched. A behavioural UART driver model answers
// the start/ready handshake in one of three modes (hold ready low, normal
// busy period, never drop ready). A monitor checks every TX_START pulse
// against the expected byte queue.
// ---------------------------------------------------------------------------
module tb_uart_tx_sched;

    localparam int M_NORMAL = 0;
    localparam int M_HOLD   = 1;
    localparam int M_NEVER  = 2;
    localparam int BUSY_LEN = 10;

    // STATUS field helpers
    localparam logic [31:0] ST_OVF   = 32'h0000_8000;
    localparam logic [31:0] ST_IDLE  = 32'h0000_4000;
    localparam logic [31:0] ST_FULL  = 32'h0000_2000;
    localparam logic [31:0] ST_EMPTY = 32'h0000_1000;

    // -----------------------------------------------------------------------
    // Clock / reset
    // -----------------------------------------------------------------------
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0;
    logic [7:0]  wr_data = 8'h00;
    logic        clr_ovf = 1'b0;
    logic        tx_ready = 1'b1;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic [31:0] status;
    logic [1:0]  dbg_state;

    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx_sched #(.DEPTH(16), .CW(5), .BUSY_TO(8)) dut (
        .CLK       (clk),
        .RST       (rst),
        .WR_EN     (wr_en),
        .WR_DATA   (wr_data),
        .CLR_OVF   (clr_ovf),
        .TX_READY  (tx_ready),
        .TX_START  (tx_start),
        .TX_DATA   (tx_data),
        .STATUS    (status),
        .DBG_STATE (dbg_state)
    );

    // -----------------------------------------------------------------------
    // Scoreboard state and checker
    // -----------------------------------------------------------------------
    logic [7:0] exp_q[$];
    int         start_cyc_q[$];
    int         start_count = 0;
    int         checks = 0;
    int         errors = 0;
    logic       prev_start = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // -----------------------------------------------------------------------
    // UART driver model
    // -----------------------------------------------------------------------
    int uart_mode = M_NORMAL;
    int busy = 0;

    always @(negedge clk) begin
        case (uart_mode)
            M_HOLD:  tx_ready = 1'b0;
            M_NEVER: tx_ready = 1'b1;
            default: begin
                if (tx_start === 1'b1) begin
                    busy = BUSY_LEN;
                    tx_ready = 1'b0;
                end else if (busy > 0) begin
                    busy--;
                    if (busy == 0) tx_ready = 1'b1;
                end else begin
                    tx_ready = 1'b1;
                end
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Monitor: every start pulse must be one cycle wide and carry the next
    // expected byte.
    // -----------------------------------------------------------------------
    always @(negedge clk) begin
        if (tx_start === 1'b1) begin
            chk("start_width", {31'b0, prev_start}, 32'd0);
            start_count++;
            start_cyc_q.push_back(cyc);
            if (exp_q.size() == 0) begin
                chk("unexpected_start", {24'b0, tx_data}, 32'hFFFF_FFFF);
            end else begin
                chk("tx_data", {24'b0, tx_data}, {24'b0, exp_q.pop_front()});
            end
        end
        prev_start = (tx_start === 1'b1);
    end

    // -----------------------------------------------------------------------
    // Driver tasks
    // -----------------------------------------------------------------------
    task automatic bus_cycle(input logic we, input logic [7:0] d, input logic clr);
        @(negedge clk);
        wr_en   = we;
        wr_data = d;
        clr_ovf = clr;
    endtask

    task automatic set_mode(input int m);
        @(posedge clk);
        #1;
        uart_mode = m;
    endtask

    task automatic fill(input logic [7:0] base);
        for (int i = 0; i < 16; i++) begin
            bus_cycle(1'b1, base + 8'(i), 1'b0);
            exp_q.push_back(base + 8'(i));
        end
        bus_cycle(1'b0, 8'h00, 1'b0);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        while (!((exp_q.size() == 0) && (status[14] === 1'b1)) && (n < budget)) begin
            @(negedge clk);
            n++;
        end
        chk(tag, {31'b0, (n < budget)}, 32'd1);
    endtask

    task automatic wait_starts(input int target, input int budget);
        int n;
        n = 0;
        while ((start_count < target) && (n < budget)) begin
            @(negedge clk);
            n++;
        end
        chk("start_seen", {31'b0, (start_count >= target)}, 32'd1);
    endtask

    // -----------------------------------------------------------------------
    // Directed tests
    // -----------------------------------------------------------------------
    initial begin
        int t0;
        int n0;
        int sc;
        int n;

        // Reset state
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_status", status, ST_IDLE | ST_EMPTY);
        chk("rst_start", {31'b0, tx_start}, 32'd0);
        chk("rst_data", {24'b0, tx_data}, 32'd0);
        chk("rst_state", {30'b0, dbg_state}, 32'd0);
        rst = 1'b0;

        // 1: single byte, latency and status progression
        bus_cycle(1'b1, 8'h41, 1'b0);
        exp_q.push_back(8'h41);
        t0 = cyc;
        bus_cycle(1'b0, 8'h00, 1'b0);
        chk("t1_status_queued", status, 32'h0000_0001);
        wait_starts(1, 10);
        chk("t1_latency", 32'(start_cyc_q[start_cyc_q.size()-1] - t0), 32'd2);
        wait_idle("t1_drain", 100);
        chk("t1_status_done", status, ST_IDLE | ST_EMPTY);
        chk("t1_data_hold", {24'b0, tx_data}, 32'h41);

        // 2: burst to full, overflow drop, drain in order
        set_mode(M_HOLD);
        sc = start_count;
        fill(8'h00);
        chk("t2_full", status, ST_FULL | 32'h10);
        bus_cycle(1'b1, 8'hAA, 1'b0);
        bus_cycle(1'b0, 8'h00, 1'b0);
        chk("t2_overflow", status, ST_OVF | ST_FULL | 32'h10);
        chk("t2_hold_no_start", 32'(start_count), 32'(sc));
        set_mode(M_NORMAL);
        wait_idle("t2_drain", 1000);
        chk("t2_status_done", status, ST_OVF | ST_IDLE | ST_EMPTY);
        bus_cycle(1'b0, 8'h00, 1'b1);
        bus_cycle(1'b0, 8'h00, 1'b0);
        chk("t2_clr_ovf", status, ST_IDLE | ST_EMPTY);

        // 3: push into a full FIFO in the same cycle as a pop
        set_mode(M_HOLD);
        fill(8'h20);
        chk("t3_full", status, ST_FULL | 32'h10);
        set_mode(M_NORMAL);
        bus_cycle(1'b1, 8'h55, 1'b0);
        exp_q.push_back(8'h55);
        bus_cycle(1'b0, 8'h00, 1'b0);
        chk("t3_push_pop", status, ST_FULL | 32'h10);
        wait_idle("t3_drain", 1000);
        chk("t3_status_done", status, ST_IDLE | ST_EMPTY);

        // 6: overflow clear, and clear coincident with a new overflow
        set_mode(M_HOLD);
        fill(8'h30);
        bus_cycle(1'b1, 8'hAB, 1'b0);
        bus_cycle(1'b0, 8'h00, 1'b0);
        chk("t6_ovf_set", status, ST_OVF | ST_FULL | 32'h10);
        bus_cycle(1'b0, 8'h00, 1'b1);
        bus_cycle(1'b0, 8'h00, 1'b0);
        chk("t6_ovf_clr", status, ST_FULL | 32'h10);
        bus_cycle(1'b1, 8'hCD, 1'b1);
        bus_cycle(1'b0, 8'h00, 1'b0);
        chk("t6_ovf_wins", status, ST_OVF | ST_FULL | 32'h10);
        set_mode(M_NORMAL);
        wait_idle("t6_drain", 1000);
        chk("t6_status_done", status, ST_OVF | ST_IDLE | ST_EMPTY);
        bus_cycle(1'b0, 8'h00, 1'b1);
        bus_cycle(1'b0, 8'h00, 1'b0);
        chk("t6_clr_final", status, ST_IDLE | ST_EMPTY);

        // 4: ready never drops; busy timeout spacing
        set_mode(M_NEVER);
        n0 = start_cyc_q.size();
        bus_cycle(1'b1, 8'h61, 1'b0);
        exp_q.push_back(8'h61);
        bus_cycle(1'b1, 8'h62, 1'b0);
        exp_q.push_back(8'h62);
        bus_cycle(1'b0, 8'h00, 1'b0);
        wait_starts(start_count + 2 - (start_cyc_q.size() - n0), 100);
        if (start_cyc_q.size() >= n0 + 2) begin
            chk("t4_spacing", 32'(start_cyc_q[n0+1] - start_cyc_q[n0]), 32'd11);
        end else begin
            chk("t4_two_starts", 32'(start_cyc_q.size() - n0), 32'd2);
        end
        wait_idle("t4_drain", 100);
        chk("t4_status_done", status, ST_IDLE | ST_EMPTY);

        // 5: reset during WAIT_DONE with five bytes queued
        set_mode(M_NORMAL);
        exp_q.push_back(8'h71);
        for (int i = 0; i < 6; i++) begin
            bus_cycle(1'b1, 8'h71 + 8'(i), 1'b0);
        end
        bus_cycle(1'b0, 8'h00, 1'b0);
        n = 0;
        while (!((dbg_state == 2'd3) && (status[7:0] == 8'd5)) && (n < 50)) begin
            @(negedge clk);
            n++;
        end
        chk("t5_reach_wait_done", {31'b0, (n < 50)}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t5_rst_status", status, ST_IDLE | ST_EMPTY);
        chk("t5_rst_start", {31'b0, tx_start}, 32'd0);
        chk("t5_rst_state", {30'b0, dbg_state}, 32'd0);
        sc = start_count;
        repeat (40) @(negedge clk);
        chk("t5_no_start", 32'(start_count), 32'(sc));
        bus_cycle(1'b1, 8'h77, 1'b0);
        exp_q.push_back(8'h77);
        bus_cycle(1'b0, 8'h00, 1'b0);
        wait_idle("t5_drain", 100);
        chk("t5_data", {24'b0, tx_data}, 32'h77);
        chk("t5_status_done", status, ST_IDLE | ST_EMPTY);

        chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog
    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
